// File: rtl/brp_pkg.sv
// Shared definitions for the branch resolution / prediction slice.
//   - funct3 encodings of the RV32I conditional branches
//   - bht_state_e : 2-bit saturating counter states
//   - bht_entry_t : one prediction table entry {valid, state, target}
//   - bht_step    : saturating counter update for a resolved conditional branch
package brp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    typedef struct packed {
        logic        valid;
        bht_state_e  state;
        logic [31:0] target;
    } bht_entry_t;

    // One step toward taken / not-taken, saturating at ST / SNT.
    function automatic bht_state_e bht_step(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Direct-mapped, untagged branch prediction table.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears every entry)
//   rd_pc         : fetch PC; rd_entry is the entry at its index (combinational)
//   wr_en         : update the entry indexed by wr_pc on this clock edge
//   wr_pc         : PC of the resolved instruction
//   wr_taken      : resolved direction (conditional branches)
//   wr_jump       : jal/jalr; counter is forced to ST instead of stepped
//   wr_target     : resolved target written into the entry
// A same-cycle read and write to one index returns the old entry (no bypass).
module branch_pred_table
    import brp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc,
    output bht_entry_t  rd_entry,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic        wr_taken,
    input  logic        wr_jump,
    input  logic [31:0] wr_target
);
    localparam int IDX = $clog2(ENTRIES);

    bht_entry_t     mem [ENTRIES];
    logic [IDX-1:0] rd_idx;
    logic [IDX-1:0] wr_idx;

    // Only the index bits of the PCs select an entry; the rest is deliberately dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc[31:IDX+2], rd_pc[1:0], wr_pc[31:IDX+2], wr_pc[1:0]};

    assign rd_idx   = rd_pc[IDX+1:2];
    assign wr_idx   = wr_pc[IDX+1:2];
    assign rd_entry = mem[rd_idx];

    // NOTE: the array is reset, so it maps to flops rather than a RAM macro;
    // that is intentional because reset must invalidate every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '{valid: 1'b0, state: WNT, target: 32'd0};
            end
        end else if (wr_en) begin
            mem[wr_idx] <= '{valid:  1'b1,
                             state:  wr_jump ? ST : bht_step(mem[wr_idx].state, wr_taken),
                             target: wr_target};
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution and prediction unit for the RV32I pipeline.
// Ports:
//   i_clk, i_reset            : clock, asynchronous active-high reset
//   i_if_pc                   : fetch PC for table lookup
//   o_if_pred_taken/_target   : combinational prediction for i_if_pc
//   i_ex_*                    : EX-stage instruction class, funct3, PC, target, carried prediction
//   o_br_un                   : comparator mode select (1 for BLT/BGE)
//   i_br_less, i_br_equal     : comparator results for rs1 vs rs2
//   o_redirect_valid/_pc      : registered one-cycle refetch request on mispredict
//   o_br_count                : resolved branch/jump count
//   o_mispred_count           : mispredict count
module branch_resolve
    import brp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_if_pred_taken,
    output logic [31:0] o_if_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_is_jalr,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);
    bht_entry_t  lookup;
    logic        cond_taken;
    logic        cond_legal;
    logic        is_jump;
    logic        live;
    logic        taken;
    logic        mispredict;
    logic [31:0] fix_pc;

    assign o_br_un = (i_ex_funct3 == F3_BLT) || (i_ex_funct3 == F3_BGE);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cond_taken = 1'b0;
        cond_legal = 1'b1;
        case (i_ex_funct3)
            F3_BEQ:           cond_taken = i_br_equal;
            F3_BNE:           cond_taken = !i_br_equal;
            F3_BLT, F3_BLTU:  cond_taken = i_br_less;
            F3_BGE, F3_BGEU:  cond_taken = !i_br_less;
            default:          cond_legal = 1'b0;
        endcase
    end

    assign is_jump = i_ex_is_jal || i_ex_is_jalr;

    // The instruction sitting in EX during a redirect pulse is wrong-path.
    assign live = i_ex_valid && ((i_ex_is_branch && cond_legal) || is_jump) && !o_redirect_valid;

    assign taken      = is_jump || (i_ex_is_branch && cond_taken);
    assign mispredict = live && ((taken != i_ex_pred_taken) ||
                                 (taken && i_ex_pred_taken && (i_ex_target != i_ex_pred_target)));
    assign fix_pc     = taken ? i_ex_target : (i_ex_pc + 32'd4);

    branch_pred_table #(.ENTRIES(ENTRIES)) u_table (
        .clk       (i_clk),
        .rst       (i_reset),
        .rd_pc     (i_if_pc),
        .rd_entry  (lookup),
        .wr_en     (live),
        .wr_pc     (i_ex_pc),
        .wr_taken  (taken),
        .wr_jump   (is_jump),
        .wr_target (i_ex_target)
    );

    assign o_if_pred_taken  = lookup.valid && lookup.state[1];
    assign o_if_pred_target = lookup.target;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= 32'd0;
            o_br_count       <= 32'd0;
            o_mispred_count  <= 32'd0;
        end else begin
            o_redirect_valid <= mispredict;
            if (mispredict) begin
                o_redirect_pc <= fix_pc;
            end
            if (live) begin
                o_br_count <= o_br_count + 32'd1;
            end
            if (mispredict) begin
                o_mispred_count <= o_mispred_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution and prediction unit for the pipelined RV32I core. It is the consumer of the branch comparator's `br_less`/`br_equal` flags and also drives the comparator's signed/unsigned select. It decodes the EX-stage branch/jump, decides the actual outcome, and compares it with the fetch-stage prediction. It raises a registered redirect on mispredict and trains a direct-mapped table of 2-bit counters plus targets, which fetch reads every cycle.

## Interface
- `ENTRIES`, 64: table depth, power of two; index = `pc[IDX+1:2]`, where IDX = log2(ENTRIES)
- `i_clk`  in  1  core clock
- `i_reset`  in  1  asynchronous, active-high reset (one clock; reset asynchronous active-high, fixed)
- `i_if_pc`  in  32  fetch PC for lookup
- `o_if_pred_taken`  out  1  valid & counter[1] at `i_if_pc` index (combinational)
- `o_if_pred_target`  out  32  stored target at `i_if_pc` index (combinational)
- `i_ex_valid`  in  1  EX holds a live instruction
- `i_ex_is_branch`, `i_ex_is_jal`, `i_ex_is_jalr`  in  1 each  instruction class, at most one set
- `i_ex_funct3`  in  3  branch condition
- `i_ex_pc`  in  32  PC of the EX instruction
- `i_ex_target`  in  32  computed taken target
- `i_ex_pred_taken`  in  1  prediction carried down the pipe
- `i_ex_pred_target`  in  32  predicted target carried down the pipe
- `o_br_un`  out  1  to comparator; 1 = signed (BLT/BGE), 0 = unsigned
- `i_br_less`, `i_br_equal`  in  1 each  comparator results for rs1 vs rs2
- `o_redirect_valid`  out  1  one-cycle pulse: flush IF/ID and refetch
- `o_redirect_pc`  out  32  refetch address
- `o_br_count`  out  32  resolved branch/jump count
- `o_mispred_count`  out  32  mispredict count

## Operation
- `o_br_un` = 1 for funct3 100/101, otherwise 0. Combinational and independent of `i_ex_valid`.
- Branch taken decode:
  - 000 BEQ: equal
  - 001 BNE: !equal
  - 100 BLT and 110 BLTU: less
  - 101 BGE and 111 BGEU: !less
  - 010/011 are illegal: treated as not taken, no table update, not counted.
- JAL and JALR are always taken.
- Live = `i_ex_valid` & (branch | jal | jalr) & !`o_redirect_valid`. While the redirect pulse is high, the EX instruction is wrong-path and is fully ignored: no update, no count, no redirect.
- Mispredict = live & (taken != pred_taken | (taken & pred_taken & target != pred_target)).
- Redirect PC = taken ? `i_ex_target` : `i_ex_pc`+4 (32-bit wrap).
- Table entry holds valid, 2-bit counter and 32-bit target.
- Counter states:
  - SNT=00
  - WNT=01
  - WT=10
  - ST=11
- On a live conditional branch: set valid, write target, and step the counter (+1 if taken, −1 if not), saturating at ST/SNT.
- On a live jal/jalr: set valid, write target, counter := ST.
- No tags: aliasing PCs share an entry.
- Counters: `o_br_count` += 1 per live instruction; `o_mispred_count` += 1 per mispredict. Both wrap modulo 2^32.

## Timing
- Lookup is zero-latency, combinational from `i_if_pc`.
- Resolution is combinational in EX cycle N. Table update, counter increment and redirect register all load on the edge ending cycle N.
- `o_redirect_valid`/`o_redirect_pc` are high for exactly cycle N+1. Back-to-back redirects are impossible, because the cycle N+1 instruction is squashed.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update value (no bypass).
- Reset values (asynchronous, including mid-operation):
  - all entries valid=0, counter=WNT, target=0
  - `o_redirect_valid`=0, `o_redirect_pc`=0
  - both counters 0
- A pending redirect is dropped on reset.

## Structure
- `brp_pkg`:
  - funct3 constants (`F3_BEQ`..`F3_BGEU`)
  - `bht_state_e` enum (SNT/WNT/WT/ST)
  - entry struct {valid, state, target}
  - saturating-step function
- Sub-module `branch_pred_table`:
  - owns the ENTRIES array with async reset
  - one combinational read port (fetch)
  - one synchronous write port (EX update)
- Top level holds the decode, mispredict logic, redirect register and counters.

## Test plan
- Reset, then `i_if_pc`=0x100 → `o_if_pred_taken`=0, `o_if_pred_target`=0, all outputs 0.
- BLT, rs1=0xFFFF_FFFF, rs2=1, comparator less=1, pred not taken, pc=0x200, target=0x180:
  - `o_br_un`=1
  - redirect pulse next cycle with pc 0x180
  - entry 0x200 becomes WT
  - lookup 0x200 → taken, 0x180
- BGEU, same operands, less=0, pred not taken → taken, redirect to target.
- BEQ equal=0, pred taken → redirect to pc+4 and `o_mispred_count` += 1. Four not-taken outcomes from ST end at SNT and then saturate.
- Redirect cycle with `i_ex_valid`=1, BNE mispredicting → ignored: no second pulse, counts unchanged.
- JALR, pred taken, pred_target 0x400, actual 0x404 → redirect 0x404 and stored target updated. Assert `i_reset` during the redirect cycle → pulse cleared immediately and the table is cleared.
